conv2_psum_collector: RTL
=========================

CONV2_PSUM_COLLECTOR -- requirements
Module: conv2_psum_collector

Interface
REQ-001 SHALL have parameter NUM_PE, default 12, the number of PE partial sums per column vector.
REQ-002 SHALL have parameter PSUM_W, default 14, the signed width of each PE partial sum.
REQ-003 SHALL have parameter ACC_W, default 18, the signed accumulator width.
REQ-004 SHALL have parameter OUT_W, default 8, the signed output width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port psum_valid, input, 1 bit: psum_in holds a column result.
REQ-008 SHALL have port psum_ready, output, 1 bit: the collector accepts psum_in.
REQ-009 SHALL have port psum_in, input, NUM_PE*PSUM_W (168) bits: PE0 at [167:154], PE11 at [13:0].
REQ-010 SHALL have port psum_last, input, 1 bit: the beat is the final channel pass of the group.
REQ-011 SHALL have port shift_amt, input, 4 bits: requantisation right-shift, sampled with the last beat.
REQ-012 SHALL have port relu_en, input, 1 bit: ReLU enable, sampled with the last beat.
REQ-013 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-014 SHALL have port out_ready, input, 1 bit: the downstream sink accepts out_data.
REQ-015 SHALL have port out_data, output, OUT_W bits: the requantised result.
REQ-016 SHALL have port out_idx, output, 4 bits: PE index 0..NUM_PE-1 of out_data.
REQ-017 SHALL have port out_last, output, 1 bit: asserted with out_idx == NUM_PE-1.
REQ-018 SHALL have port busy, output, 1 bit: a group is in progress or draining.

Function
REQ-019 SHALL implement FSM states IDLE, ACCUM, DRAIN; IDLE->ACCUM on an accepted non-last beat; IDLE/ACCUM->DRAIN on an accepted last beat; DRAIN->IDLE on acceptance of the out_last beat.
REQ-020 SHALL drive psum_ready = 1 in IDLE/ACCUM and 0 in DRAIN; psum_valid in DRAIN SHALL be ignored.
REQ-021 SHALL, on each accepted beat (psum_valid & psum_ready), update every acc[k] to sext(psum slice k) when in IDLE, else acc[k] + sext(psum slice k).
REQ-022 SHALL saturate each accumulator to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; it SHALL never wrap.
REQ-023 SHALL accept a beat carrying psum_last in IDLE as a one-pass group.
REQ-024 SHALL latch shift_amt and relu_en on the accepted last beat; changes at other times SHALL have no effect.
REQ-025 SHALL requantise each output as: arithmetic right shift of acc by shift_amt (truncate toward -inf), then clamp negatives to 0 if relu_en, then saturate to [-128,127].
REQ-026 SHALL assert out_valid the cycle after the last beat is accepted, with out_idx = 0.
REQ-027 SHALL hold out_data, out_idx and out_last stable while out_valid & !out_ready.
REQ-028 SHALL advance out_idx by one on each out_valid & out_ready, with no bubble when out_ready stays high; 12 drain cycles minimum.
REQ-029 SHALL drive busy = (state != IDLE).

Reset
REQ-030 SHALL, on rst asserted (asynchronously, at any time including mid-drain), enter IDLE, clear all accumulators, out_data, out_idx, latched shift/relu, out_valid, out_last and busy to 0, and drive psum_ready = 0 while rst is high.
REQ-031 SHALL discard any partially drained group on reset; the first accepted beat after reset starts a new group.

Structure
REQ-032 SHALL place NUM_PE, PSUM_W, ACC_W, OUT_W and the FSM state enumeration in the shared package conv2_pkg.
REQ-033 SHALL implement the shift/ReLU/saturate path as one combinational sub-module, conv2_requant, instantiated once on the muxed accumulator selected by out_idx.

Verification
REQ-034 One pass: all 12 slices = 100, last=1, shift=0, relu=0 -> outputs idx0..11 = 100 each, out_last on idx 11, out_valid the cycle after the handshake.
REQ-035 Three passes: slice k = k+1 on each pass, shift=1 -> out_data[k] = (3(k+1))>>1, i.e. idx0 = 1, idx11 = 18.
REQ-036 Sign/ReLU: slice0 = -300, slice1 = 5000 (one pass), shift=2; relu=1 -> idx0 = 0, idx1 = 127; relu=0 -> idx0 = -75, idx1 = 127.
REQ-037 Backpressure: out_ready toggles 1,0,0,1 during drain -> no index skipped or repeated, data stable while stalled, psum_valid during drain not accepted.
REQ-038 Accumulator saturation: 20 passes of slice = 8191 -> acc clamps at 131071; shift=10 -> out_data 127.
REQ-039 Reset mid-drain: assert rst at out_idx = 5 -> out_valid = 0 immediately; next group of slices = 7 outputs 7 from idx 0.

Source files
------------

// File: rtl/conv2_pkg.sv
// Shared sizing constants and FSM state encoding for the conv2 partial-sum collector.
package conv2_pkg;
  localparam int NUM_PE = 12;
  localparam int PSUM_W = 14;
  localparam int ACC_W  = 18;
  localparam int OUT_W  = 8;
  localparam int IDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/conv2_requant.sv
// Combinational requantiser: arithmetic right shift, optional ReLU, saturate to OUT_W.
module conv2_requant #(
  parameter int ACC_W = conv2_pkg::ACC_W,
  parameter int OUT_W = conv2_pkg::OUT_W
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic        [3:0]       shift_amt,
  input  logic                    relu_en,
  output logic signed [OUT_W-1:0] q
);
  localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Q_MIN = ACC_W'(-(1 << (OUT_W - 1)));

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = acc >>> shift_amt;
    if (relu_en && shifted[ACC_W-1]) begin
      shifted = '0;
    end
    if (shifted > Q_MAX) begin
      q = Q_MAX[OUT_W-1:0];
    end else if (shifted < Q_MIN) begin
      q = Q_MIN[OUT_W-1:0];
    end else begin
      q = shifted[OUT_W-1:0];
    end
  end
endmodule

// File: rtl/conv2_psum_collector.sv
// Accumulates per-PE partial sums over channel passes, then drains one requantised
// result per PE index through a valid/ready output.
module conv2_psum_collector #(
  parameter int NUM_PE = conv2_pkg::NUM_PE,
  parameter int PSUM_W = conv2_pkg::PSUM_W,
  parameter int ACC_W  = conv2_pkg::ACC_W,
  parameter int OUT_W  = conv2_pkg::OUT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     psum_valid,
  output logic                     psum_ready,
  input  logic [NUM_PE*PSUM_W-1:0] psum_in,
  input  logic                     psum_last,
  input  logic [3:0]               shift_amt,
  input  logic                     relu_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic [3:0]               out_idx,
  output logic                     out_last,
  output logic                     busy
);
  import conv2_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(NUM_PE - 1);

  state_t                  state_reg, state_next;
  logic signed [ACC_W-1:0] acc_reg  [NUM_PE];
  logic signed [ACC_W-1:0] acc_next [NUM_PE];
  logic [3:0]              idx_reg;
  logic [3:0]              shift_reg;
  logic                    relu_reg;
  logic                    psum_fire;
  logic                    drain_step;
  logic                    drain_done;
  logic signed [ACC_W-1:0] acc_sel;
  logic signed [OUT_W-1:0] q_data;

  // Kept independent of psum_ready so the FSM comb block has no feedback path.
  assign psum_fire  = psum_valid && !rst && (state_reg != DRAIN);
  assign drain_step = (state_reg == DRAIN) && out_ready;
  assign drain_done = drain_step && (idx_reg == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    psum_ready = 1'b0;
    out_valid  = 1'b0;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        psum_ready = !rst;
        if (psum_fire) begin
          state_next = psum_last ? DRAIN : ACCUM;
        end
      end
      ACCUM: begin
        psum_ready = !rst;
        if (psum_fire && psum_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (drain_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Per-PE saturating accumulate; the first beat of a group loads instead of adding.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PE; gi++) begin : g_pe
      logic [PSUM_W-1:0]      slice;
      logic signed [ACC_W:0]  base;
      logic signed [ACC_W:0]  sum;
      assign slice = psum_in[(NUM_PE-1-gi)*PSUM_W +: PSUM_W];
      assign base  = (state_reg == IDLE) ? '0 : {acc_reg[gi][ACC_W-1], acc_reg[gi]};
      assign sum   = base + {{(ACC_W+1-PSUM_W){slice[PSUM_W-1]}}, slice};
      assign acc_next[gi] = (sum[ACC_W] != sum[ACC_W-1])
                          ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}}
                          : sum[ACC_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_PE; k++) begin
        acc_reg[k] <= '0;
      end
    end else if (psum_fire) begin
      for (int k = 0; k < NUM_PE; k++) begin
        acc_reg[k] <= acc_next[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      relu_reg  <= 1'b0;
    end else if (psum_fire && psum_last) begin
      shift_reg <= shift_amt;
      relu_reg  <= relu_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg <= '0;
    end else if (drain_step) begin
      idx_reg <= drain_done ? 4'd0 : idx_reg + 4'd1;
    end
  end

  // Accumulators are frozen during drain, so the muxed output holds while stalled.
  assign acc_sel = acc_reg[idx_reg];

  conv2_requant #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_requant (
    .acc       (acc_sel),
    .shift_amt (shift_reg),
    .relu_en   (relu_reg),
    .q         (q_data)
  );

  assign out_data = q_data;
  assign out_idx  = idx_reg;
  assign out_last = (state_reg == DRAIN) && (idx_reg == LAST_IDX);
endmodule
